// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle synchronous imem,
// queues returned {instr, pc} pairs and hands them to decode over valid/ready.
module fetch_stage #(
  parameter int INSTRUCTION_WIDTH     = 32,
  parameter int PROGRAM_ADDRESS_WIDTH = 6,
  parameter int QUEUE_DEPTH           = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             imem_req,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]     imem_rdata,
  input  logic                             redirect_valid,
  input  logic [PROGRAM_ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INSTRUCTION_WIDTH-1:0]     out_instr,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] out_pc
);

  localparam int IW      = INSTRUCTION_WIDTH;
  localparam int PAW     = PROGRAM_ADDRESS_WIDTH;
  localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int ENTRY_W = IW + PAW;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);

  logic [PAW-1:0]     pc_q, pc_d;
  logic [PAW-1:0]     req_pc_q, req_pc_d;
  logic               pending_q, pending_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];

  logic               pop_s;
  logic               push_s;
  logic               req_core_s;
  logic [CNT_W:0]     in_flight_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Credit counts the outstanding read so a queue slot is always free when it returns.
  assign pop_s       = (count_q != CNT_W'(0)) & out_ready;
  assign in_flight_s = {1'b0, count_q} + (CNT_W + 1)'(pending_q);
  assign req_core_s  = !redirect_valid & (in_flight_s < CREDIT_LIMIT + (CNT_W + 1)'(pop_s));
  assign push_s      = pending_q & !kill_q & !redirect_valid;

  // rst gates only the port so nothing issues while the block is held in reset.
  assign imem_req  = rst & req_core_s;
  assign imem_addr = pc_q;
  assign out_valid = (count_q != CNT_W'(0));
  assign out_instr = mem_q[head_q][ENTRY_W-1 -: IW];
  assign out_pc    = mem_q[head_q][PAW-1:0];

  // Next-state for PC, request tracking and queue pointers.
  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    pending_d = req_core_s;
    kill_d    = redirect_valid;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (req_core_s) begin
      pc_d     = pc_q + PAW'(1);
      req_pc_d = pc_q;
    end else begin
      pc_d     = pc_q;
    end
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = PTR_W'(0);
      tail_d  = PTR_W'(0);
      count_d = CNT_W'(0);
    end else begin
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= PAW'(0);
      req_pc_q  <= PAW'(0);
      pending_q <= 1'b0;
      kill_q    <= 1'b0;
      count_q   <= CNT_W'(0);
      head_q    <= PTR_W'(0);
      tail_q    <= PTR_W'(0);
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      pending_q <= pending_d;
      kill_q    <= kill_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Queue storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= ENTRY_W'(0);
      end
    end else if (push_s) begin
      mem_q[tail_q] <= {imem_rdata, req_pc_q};
    end else begin
      mem_q[tail_q] <= mem_q[tail_q];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 1-cycle imem model returning 0x100+addr, and a
// scoreboard of expected PCs compared against every decode handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [5:0]  out_pc;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  fetch_stage #(
    .INSTRUCTION_WIDTH    (32),
    .PROGRAM_ADDRESS_WIDTH(6),
    .QUEUE_DEPTH          (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word k holds 0x100 + k.
  always @(posedge clk) begin
    if (imem_req === 1'b1) imem_rdata <= 32'h100 + {26'd0, imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(6'(first + i));
  endtask

  task automatic sb_step();
    logic [5:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra_pop: observed pc %0h expected no handshake", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", {26'd0, out_pc}, {26'd0, e});
        chk("sb_instr", out_instr, 32'h100 + {26'd0, e});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    sb_step();
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    out_ready = 1'b1;
    cyc();
    cyc();
    smp();
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", {26'd0, out_pc}, 32'd0);

    // 1: latency from reset release and steady streaming
    cyc();
    rst = 1'b1;
    push_range(0, 6);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      smp();
      if (c == 0) begin
        chk("t1_req_c0", {31'd0, imem_req}, 32'd1);
        chk("t1_addr_c0", {26'd0, imem_addr}, 32'd0);
      end
      if (c < 2) chk("t1_no_valid_early", {31'd0, out_valid}, 32'd0);
      if (c == 2) begin
        chk("t1_valid_c2", {31'd0, out_valid}, 32'd1);
        chk("t1_pc_c2", {26'd0, out_pc}, 32'd0);
        chk("t1_instr_c2", out_instr, 32'h100);
      end
    end
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: backpressure fills the queue, then drains with no loss or duplicate
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) cyc();
      if (c == 6) begin
        push_range(0, 5);
        out_ready = 1'b1;
      end
      smp();
      if (c >= 2 && c < 6) begin
        chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_hold_pc", {26'd0, out_pc}, 32'd0);
        chk("t2_hold_instr", out_instr, 32'h100);
        chk("t2_no_req_full", {31'd0, imem_req}, 32'd0);
      end
    end
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: redirect while pc 5 is pending
    do_reset();
    out_ready = 1'b1;
    push_range(0, 5);
    push_range(6'h20, 3);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      redirect_valid = (c == 6);
      redirect_pc = 6'h20;
      smp();
      if (c == 6) chk("t3_req_blocked", {31'd0, imem_req}, 32'd0);
      if (c == 7) begin
        chk("t3_flushed", {31'd0, out_valid}, 32'd0);
        chk("t3_req_target", {31'd0, imem_req}, 32'd1);
        chk("t3_addr_target", {26'd0, imem_addr}, 32'h20);
      end
      if (c == 8) chk("t3_still_empty", {31'd0, out_valid}, 32'd0);
      if (c == 9) chk("t3_target_pc", {26'd0, out_pc}, 32'h20);
    end
    redirect_valid = 1'b0;
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: PC wraps 62, 63, 0, 1
    do_reset();
    out_ready = 1'b1;
    push_range(62, 2);
    push_range(0, 2);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      redirect_valid = (c == 0);
      redirect_pc = 6'd62;
      smp();
      if (c == 1) chk("t4_addr_62", {26'd0, imem_addr}, 32'd62);
      if (c == 3) chk("t4_addr_wrap", {26'd0, imem_addr}, 32'd0);
      if (c == 2) chk("t4_empty_c2", {31'd0, out_valid}, 32'd0);
      if (c == 3) chk("t4_first_pc", {26'd0, out_pc}, 32'd62);
    end
    redirect_valid = 1'b0;
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: redirect coincides with the pop of pc 7
    do_reset();
    out_ready = 1'b1;
    push_range(0, 8);
    push_range(6'h11, 2);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) cyc();
      redirect_valid = (c == 9);
      redirect_pc = 6'h11;
      smp();
      if (c == 9) chk("t5_pop_pc7", {26'd0, out_pc}, 32'd7);
      if (c == 10 || c == 11) chk("t5_flushed", {31'd0, out_valid}, 32'd0);
      if (c == 12) chk("t5_target_valid", {31'd0, out_valid}, 32'd1);
    end
    redirect_valid = 1'b0;
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: asynchronous reset mid-stream with a request outstanding
    do_reset();
    out_ready = 1'b1;
    push_range(0, 3);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      smp();
    end
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_req", {31'd0, imem_req}, 32'd0);
    chk("t6_async_pc", {26'd0, out_pc}, 32'd0);
    chk("t6_async_instr", out_instr, 32'd0);
    chk("t6_sb_empty_pre", 32'(exp_q.size()), 32'd0);
    cyc();
    rst = 1'b1;
    push_range(0, 2);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      smp();
      if (c < 2) chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
